// File: rtl/memsplit_rr_arb_if.sv
// memsplit_rr_arb_if: split-transaction 32-bit memory bus (request/ack, then in-order read responses)
// Master drives req/we/addr/be/wdata and receives ack/resp/rdata; Slave is the mirror view.
interface MemSplit32;
  logic        req;
  logic        ack;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        resp;
  logic [31:0] rdata;
  modport Master (output req, we, addr, be, wdata, input ack, resp, rdata);
  modport Slave (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/memsplit_rr_arb.sv
// memsplit_rr_arb: two-requester arbiter onto one split-transaction target with in-order read response routing
// clk_i/rst_ni: clock, synchronous active-low reset; m0/m1: requesters; s: shared target;
// occ_bo: outstanding reads in the routing FIFO; err_o: sticky flag for a response with nothing outstanding.
module memsplit_rr_arb #(
  parameter int FIFO_DEPTH_POW = 2,
  parameter bit FIXED_PRIO     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  MemSplit32.Slave              m0,
  MemSplit32.Slave              m1,
  MemSplit32.Master             s,
  output logic [FIFO_DEPTH_POW:0] occ_bo,
  output logic                  err_o
);
  localparam int DEPTH = 1 << FIFO_DEPTH_POW;
  logic                      rr_q, lock_q, lock_id_q;
  logic [DEPTH-1:0]          fifo_q;
  logic [FIFO_DEPTH_POW-1:0] wp_q, rp_q;
  logic full, empty, el0, el1, gnt_v, gnt_id, s_req, s_we, done, push, pop, head;
  assign full  = occ_bo == (FIFO_DEPTH_POW+1)'(DEPTH);
  assign empty = occ_bo == '0;
  // reads need a free routing slot, writes never produce a response
  assign el0 = rst_ni & m0.req & (m0.we | ~full);
  assign el1 = rst_ni & m1.req & (m1.we | ~full);
  // a stalled transfer keeps its grant until acked so the target sees stable fields
  assign gnt_v  = lock_q ? rst_ni : el0 | el1;
  assign gnt_id = lock_q ? lock_id_q : (el0 & el1) ? (FIXED_PRIO ? 1'b0 : rr_q) : el1;
  assign s_req  = gnt_v & (gnt_id ? m1.req : m0.req);
  assign s_we   = gnt_v & (gnt_id ? m1.we : m0.we);
  assign s.req   = s_req;
  assign s.we    = s_we;
  assign s.addr  = gnt_v ? (gnt_id ? m1.addr : m0.addr) : '0;
  assign s.be    = gnt_v ? (gnt_id ? m1.be : m0.be) : '0;
  assign s.wdata = gnt_v ? (gnt_id ? m1.wdata : m0.wdata) : '0;
  assign done   = s_req & s.ack;
  assign m0.ack = done & ~gnt_id;
  assign m1.ack = done & gnt_id;
  assign push = done & ~s_we;
  assign pop  = rst_ni & s.resp & ~empty;
  assign head = fifo_q[rp_q];
  assign m0.resp  = pop & ~head;
  assign m1.resp  = pop & head;
  assign m0.rdata = (pop & ~head) ? s.rdata : '0;
  assign m1.rdata = (pop & head) ? s.rdata : '0;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      occ_bo    <= '0;
      err_o     <= 1'b0;
    end else begin
      lock_q    <= s_req & ~s.ack;
      lock_id_q <= gnt_id;
      if (done) rr_q <= ~gnt_id;
      if (push) begin
        fifo_q[wp_q] <= gnt_id;
        wp_q         <= wp_q + FIFO_DEPTH_POW'(1);
      end
      if (pop) rp_q <= rp_q + FIFO_DEPTH_POW'(1);
      occ_bo <= occ_bo + (FIFO_DEPTH_POW+1)'(push) - (FIFO_DEPTH_POW+1)'(pop);
      if (s.resp & empty) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_memsplit_rr_arb.sv
// tb_memsplit_rr_arb: randomized scoreboard bench for memsplit_rr_arb against a queue-based reference model
module tb_memsplit_rr_arb;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] occ;
  logic       err;
  MemSplit32 m0_if();
  MemSplit32 m1_if();
  MemSplit32 s_if();
  memsplit_rr_arb dut (
    .clk_i(clk), .rst_ni(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if),
    .occ_bo(occ), .err_o(err)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  typedef struct packed {logic id; logic [31:0] d;} exp_t;
  exp_t exp_q[$];
  bit          pend[2];
  bit          pwe[2];
  logic [31:0] paddr[2];
  logic [31:0] pwd[2];
  logic [3:0]  pbe[2];
  int          rr;
  bit          lk;
  int          lk_id;
  int          ofifo[$];
  bit          merr;
  bit          el[2];
  bit          gv;
  int          g;
  bit          done;
  exp_t        e;
  int p_req[4]  = '{100, 80, 90, 60};
  int p_we[4]   = '{0, 35, 40, 50};
  int p_ack[4]  = '{100, 100, 40, 70};
  int p_resp[4] = '{70, 15, 50, 40};
  int p_rst[4]  = '{0, 0, 1, 3};
  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endtask
  task automatic drive_m();
    m0_if.req = pend[0]; m0_if.we = pwe[0]; m0_if.addr = paddr[0]; m0_if.be = pbe[0]; m0_if.wdata = pwd[0];
    m1_if.req = pend[1]; m1_if.we = pwe[1]; m1_if.addr = paddr[1]; m1_if.be = pbe[1]; m1_if.wdata = pwd[1];
  endtask
  always @(negedge clk) begin
    if (m0_if.resp || m1_if.resp || exp_q.size() > 0) begin
      if (exp_q.size() == 0)
        chk("resp_unexpected", {30'd0, m1_if.resp, m0_if.resp}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("resp_route", {30'd0, m1_if.resp, m0_if.resp}, e.id ? 32'd2 : 32'd1);
        if (e.id ? m1_if.resp : m0_if.resp)
          chk("resp_rdata", e.id ? m1_if.rdata : m0_if.rdata, e.d);
      end
    end
  end
  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; pwe[i] = 0; paddr[i] = '0; pwd[i] = '0; pbe[i] = '0;
    end
    drive_m();
    s_if.ack = 0; s_if.resp = 0; s_if.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rr = 0; lk = 0; lk_id = 0; merr = 0; ofifo.delete();
    for (int ph = 0; ph < 4; ph++) begin
      for (int cyc = 0; cyc < 300; cyc++) begin
        rst_n = !(cyc == 0 || $urandom_range(99) < p_rst[ph]);
        for (int i = 0; i < 2; i++)
          if (!pend[i] && $urandom_range(99) < p_req[ph]) begin
            pend[i]  = 1;
            pwe[i]   = $urandom_range(99) < p_we[ph];
            paddr[i] = $urandom;
            pwd[i]   = $urandom;
            pbe[i]   = 4'($urandom);
          end
        drive_m();
        s_if.ack   = $urandom_range(99) < p_ack[ph];
        s_if.resp  = $urandom_range(99) < p_resp[ph];
        s_if.rdata = $urandom;
        for (int i = 0; i < 2; i++)
          el[i] = rst_n && pend[i] && (pwe[i] || ofifo.size() < 4);
        gv = 0; g = 0;
        if (!rst_n) gv = 0;
        else if (lk) begin gv = 1; g = lk_id; end
        else if (el[0] && el[1]) begin gv = 1; g = rr; end
        else if (el[0]) begin gv = 1; g = 0; end
        else if (el[1]) begin gv = 1; g = 1; end
        done = gv && s_if.ack;
        if (rst_n && s_if.resp && ofifo.size() > 0) begin
          e.id = ofifo[0] == 1;
          e.d  = s_if.rdata;
          exp_q.push_back(e);
        end
        @(negedge clk);
        chk("s_req", {31'd0, s_if.req}, {31'd0, gv});
        chk("s_we", {31'd0, s_if.we}, {31'd0, gv && pwe[g]});
        chk("s_addr", s_if.addr, gv ? paddr[g] : 32'd0);
        chk("s_be", {28'd0, s_if.be}, gv ? {28'd0, pbe[g]} : 32'd0);
        chk("s_wdata", s_if.wdata, gv ? pwd[g] : 32'd0);
        chk("m0_ack", {31'd0, m0_if.ack}, {31'd0, done && g == 0});
        chk("m1_ack", {31'd0, m1_if.ack}, {31'd0, done && g == 1});
        chk("occ", {29'd0, occ}, ofifo.size());
        chk("err", {31'd0, err}, {31'd0, merr});
        @(posedge clk);
        if (!rst_n) begin
          rr = 0; lk = 0; merr = 0; ofifo.delete();
        end else begin
          if (s_if.resp) begin
            if (ofifo.size() > 0) void'(ofifo.pop_front());
            else merr = 1;
          end
          lk = gv && !s_if.ack;
          lk_id = g;
          if (done) begin
            rr = 1 - g;
            if (!pwe[g]) ofifo.push_back(g);
            pend[g] = 0;
          end
        end
        #1;
      end
    end
    s_if.resp = 0;
    @(negedge clk);
    chk("exp_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
